// File: rtl/uart_cmd_parser_pkg.sv
// Shared definitions for the UART motor-command frame parser: state encoding,
// frame constants and the frame checksum.
package uart_cmd_parser_pkg;

    localparam logic [2:0] ST_HUNT      = 3'd0;
    localparam logic [2:0] ST_GET_CMD   = 3'd1;
    localparam logic [2:0] ST_GET_LEFT  = 3'd2;
    localparam logic [2:0] ST_GET_RIGHT = 3'd3;
    localparam logic [2:0] ST_GET_CHK   = 3'd4;

    localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hAA;
    localparam int unsigned FRAME_LEN         = 5;

    function automatic logic [7:0] frame_checksum(input logic [7:0] cmd_b,
                                                  input logic [7:0] left_b,
                                                  input logic [7:0] right_b);
        return cmd_b ^ left_b ^ right_b;
    endfunction

endpackage

// File: rtl/uart_cmd_parser_timeout_counter.sv
// Idle-cycle counter that raises expired on reaching LIMIT and then holds
// there until cleared, so expiry never wraps or retriggers.
module timeout_counter #(
    parameter logic [31:0] LIMIT = 32'd100
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [31:0] count_q;
    logic [31:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != LIMIT)) begin
            count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == LIMIT);

endmodule

// File: rtl/uart_cmd_parser.sv
// Assembles SYNC/CMD/LEFT/RIGHT/CHK frames from the UART byte stream and holds
// the last good drive command, zeroing it when the link watchdog expires.
module uart_cmd_parser
    import uart_cmd_parser_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH   = 8,
    parameter logic [DATA_WIDTH-1:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT,
    parameter logic [31:0]           BYTE_TIMEOUT = 32'd50000,
    parameter logic [31:0]           WATCHDOG     = 32'd48000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_valid,
    output logic [DATA_WIDTH-1:0] cmd,
    output logic [DATA_WIDTH-1:0] left_speed,
    output logic [DATA_WIDTH-1:0] right_speed,
    output logic                  frame_valid,
    output logic                  frame_err,
    output logic [7:0]            err_count,
    output logic                  link_alive
);

    logic [2:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] sh_cmd_q, sh_cmd_d;
    logic [DATA_WIDTH-1:0] sh_left_q, sh_left_d;
    logic [DATA_WIDTH-1:0] sh_right_q, sh_right_d;

    logic [DATA_WIDTH-1:0] cmd_q, cmd_d;
    logic [DATA_WIDTH-1:0] left_q, left_d;
    logic [DATA_WIDTH-1:0] right_q, right_d;
    logic                  frame_valid_q, frame_valid_d;
    logic                  frame_err_q, frame_err_d;
    logic [7:0]            err_count_q, err_count_d;
    logic                  link_alive_q, link_alive_d;

    logic good_frame;
    logic bad_frame;
    logic gap_timeout;
    logic gap_expired;
    logic wd_expired;

    timeout_counter #(.LIMIT(BYTE_TIMEOUT)) u_gap_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (rx_valid || (state_q == ST_HUNT)),
        .enable  (state_q != ST_HUNT),
        .expired (gap_expired)
    );

    timeout_counter #(.LIMIT(WATCHDOG)) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (good_frame),
        .enable  (1'b1),
        .expired (wd_expired)
    );

    always_comb begin
        state_d     = state_q;
        sh_cmd_d    = sh_cmd_q;
        sh_left_d   = sh_left_q;
        sh_right_d  = sh_right_q;
        good_frame  = 1'b0;
        bad_frame   = 1'b0;
        gap_timeout = 1'b0;

        if (rx_valid) begin
            case (state_q)
                ST_HUNT: begin
                    if (rx_data == SYNC_BYTE) begin
                        state_d = ST_GET_CMD;
                    end
                end
                ST_GET_CMD: begin
                    sh_cmd_d = rx_data;
                    state_d  = ST_GET_LEFT;
                end
                ST_GET_LEFT: begin
                    sh_left_d = rx_data;
                    state_d   = ST_GET_RIGHT;
                end
                ST_GET_RIGHT: begin
                    sh_right_d = rx_data;
                    state_d    = ST_GET_CHK;
                end
                ST_GET_CHK: begin
                    if (rx_data == frame_checksum(sh_cmd_q, sh_left_q, sh_right_q)) begin
                        good_frame = 1'b1;
                    end else begin
                        bad_frame = 1'b1;
                    end
                    state_d = ST_HUNT;
                end
                default: state_d = ST_HUNT;
            endcase
        end else if ((state_q != ST_HUNT) && gap_expired) begin
            // A byte landing in the expiry cycle takes the branch above instead.
            gap_timeout = 1'b1;
            state_d     = ST_HUNT;
        end
    end

    always_comb begin
        cmd_d         = cmd_q;
        left_d        = left_q;
        right_d       = right_q;
        link_alive_d  = link_alive_q;
        frame_valid_d = good_frame;
        frame_err_d   = bad_frame || gap_timeout;
        err_count_d   = err_count_q;

        if (good_frame) begin
            cmd_d        = sh_cmd_q;
            left_d       = sh_left_q;
            right_d      = sh_right_q;
            link_alive_d = 1'b1;
        end else if (wd_expired) begin
            cmd_d        = '0;
            left_d       = '0;
            right_d      = '0;
            link_alive_d = 1'b0;
        end

        if ((bad_frame || gap_timeout) && (err_count_q != '1)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_HUNT;
            sh_cmd_q      <= '0;
            sh_left_q     <= '0;
            sh_right_q    <= '0;
            cmd_q         <= '0;
            left_q        <= '0;
            right_q       <= '0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            err_count_q   <= '0;
            link_alive_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            sh_cmd_q      <= sh_cmd_d;
            sh_left_q     <= sh_left_d;
            sh_right_q    <= sh_right_d;
            cmd_q         <= cmd_d;
            left_q        <= left_d;
            right_q       <= right_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
            err_count_q   <= err_count_d;
            link_alive_q  <= link_alive_d;
        end
    end

    assign cmd         = cmd_q;
    assign left_speed  = left_q;
    assign right_speed = right_q;
    assign frame_valid = frame_valid_q;
    assign frame_err   = frame_err_q;
    assign err_count   = err_count_q;
    assign link_alive  = link_alive_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed self-checking bench for uart_cmd_parser with short byte-gap and
// watchdog limits so the timeout paths are reachable quickly.
module tb_uart_cmd_parser;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic [7:0] cmd;
    logic [7:0] left_speed;
    logic [7:0] right_speed;
    logic       frame_valid;
    logic       frame_err;
    logic [7:0] err_count;
    logic       link_alive;

    int unsigned checks = 0;
    int unsigned errors = 0;

    uart_cmd_parser #(
        .DATA_WIDTH   (8),
        .SYNC_BYTE    (8'hAA),
        .BYTE_TIMEOUT (32'd100),
        .WATCHDOG     (32'd1000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .cmd         (cmd),
        .left_speed  (left_speed),
        .right_speed (right_speed),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .err_count   (err_count),
        .link_alive  (link_alive)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Returns 1 time unit after the edge that captured the byte.
    task automatic send_byte(input logic [7:0] b, input int unsigned gap);
        repeat (gap) @(posedge clk);
        #1;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [7:0] l, input logic [7:0] r,
                              input logic [7:0] k, input int unsigned gap);
        send_byte(8'hAA, gap);
        send_byte(c, gap);
        send_byte(l, gap);
        send_byte(r, gap);
        send_byte(k, gap);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL sim_time_limit got %0d expected %0d", 1, 0);
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd", cmd, 8'h00);
        check("rst_left", left_speed, 8'h00);
        check("rst_right", right_speed, 8'h00);
        check("rst_fv", frame_valid, 1'b0);
        check("rst_fe", frame_err, 1'b0);
        check("rst_errcnt", err_count, 8'h00);
        check("rst_link", link_alive, 1'b0);
        rst = 1'b0;
        next_cycle();

        // Good frame, 20-cycle gaps
        send_frame(8'h01, 8'h40, 8'hC0, 8'h81, 20);
        check("f1_fv", frame_valid, 1'b1);
        check("f1_fe", frame_err, 1'b0);
        check("f1_cmd", cmd, 8'h01);
        check("f1_left", left_speed, 8'h40);
        check("f1_right", right_speed, 8'hC0);
        check("f1_link", link_alive, 1'b1);
        next_cycle();
        check("f1_fv_once", frame_valid, 1'b0);

        // Bad checksum
        send_frame(8'h01, 8'h40, 8'hC0, 8'h00, 2);
        check("bad_fe", frame_err, 1'b1);
        check("bad_fv", frame_valid, 1'b0);
        check("bad_errcnt", err_count, 8'd1);
        check("bad_cmd_kept", cmd, 8'h01);
        check("bad_left_kept", left_speed, 8'h40);
        check("bad_right_kept", right_speed, 8'hC0);
        next_cycle();
        check("bad_fe_once", frame_err, 1'b0);

        // Leading garbage in HUNT is ignored
        send_byte(8'h55, 2);
        send_byte(8'h33, 2);
        check("junk_fe", frame_err, 1'b0);
        check("junk_errcnt", err_count, 8'd1);
        send_frame(8'h02, 8'h10, 8'h10, 8'h02, 2);
        check("f3_fv", frame_valid, 1'b1);
        check("f3_cmd", cmd, 8'h02);
        check("f3_left", left_speed, 8'h10);
        check("f3_right", right_speed, 8'h10);

        // Inter-byte timeout
        send_byte(8'hAA, 2);
        send_byte(8'h03, 2);
        repeat (100) next_cycle();
        check("gap_not_yet", frame_err, 1'b0);
        next_cycle();
        check("gap_fe", frame_err, 1'b1);
        check("gap_errcnt", err_count, 8'd2);
        send_byte(8'h04, 2);
        send_byte(8'h05, 2);
        send_byte(8'h06, 2);
        check("gap_trail_fv", frame_valid, 1'b0);
        check("gap_trail_fe", frame_err, 1'b0);
        check("gap_trail_cmd", cmd, 8'h02);
        check("gap_trail_errcnt", err_count, 8'd2);

        // Byte arriving in the expiry cycle is accepted
        send_byte(8'hAA, 2);
        send_byte(8'h07, 2);
        send_byte(8'h08, 100);
        check("edge_no_fe", frame_err, 1'b0);
        send_byte(8'h09, 2);
        send_byte(8'h06, 2);
        check("edge_fv", frame_valid, 1'b1);
        check("edge_cmd", cmd, 8'h07);
        check("edge_left", left_speed, 8'h08);
        check("edge_right", right_speed, 8'h09);
        check("edge_errcnt", err_count, 8'd2);

        // Watchdog
        repeat (1000) next_cycle();
        check("wd_not_yet_link", link_alive, 1'b1);
        check("wd_not_yet_cmd", cmd, 8'h07);
        next_cycle();
        check("wd_link", link_alive, 1'b0);
        check("wd_cmd", cmd, 8'h00);
        check("wd_left", left_speed, 8'h00);
        check("wd_right", right_speed, 8'h00);
        check("wd_fe", frame_err, 1'b0);
        send_frame(8'h05, 8'hF6, 8'h0A, 8'hF9, 2);
        check("wd_rec_fv", frame_valid, 1'b1);
        check("wd_rec_link", link_alive, 1'b1);
        check("wd_rec_cmd", cmd, 8'h05);
        check("wd_rec_left", left_speed, 8'hF6);
        check("wd_rec_right", right_speed, 8'h0A);

        // Error counter saturation (starts at 2)
        for (int i = 0; i < 252; i++) send_frame(8'h01, 8'h40, 8'hC0, 8'h00, 0);
        check("sat_fe", err_count, 8'hFE);
        send_frame(8'h01, 8'h40, 8'hC0, 8'h00, 0);
        check("sat_ff", err_count, 8'hFF);
        for (int i = 0; i < 47; i++) send_frame(8'h01, 8'h40, 8'hC0, 8'h00, 0);
        check("sat_hold", err_count, 8'hFF);
        check("sat_fe_pulse", frame_err, 1'b1);

        // Reset mid-frame
        send_byte(8'hAA, 0);
        send_byte(8'h01, 0);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        check("mrst_cmd", cmd, 8'h00);
        check("mrst_left", left_speed, 8'h00);
        check("mrst_right", right_speed, 8'h00);
        check("mrst_link", link_alive, 1'b0);
        check("mrst_errcnt", err_count, 8'h00);
        check("mrst_fe", frame_err, 1'b0);
        send_byte(8'h40, 2);
        send_byte(8'hC0, 2);
        send_byte(8'h81, 2);
        check("mrst_partial_fv", frame_valid, 1'b0);
        check("mrst_partial_cmd", cmd, 8'h00);
        send_frame(8'h01, 8'h40, 8'hC0, 8'h81, 2);
        check("mrst_good_fv", frame_valid, 1'b1);
        check("mrst_good_cmd", cmd, 8'h01);
        check("mrst_good_left", left_speed, 8'h40);
        check("mrst_good_right", right_speed, 8'hC0);
        check("mrst_good_link", link_alive, 1'b1);
        check("mrst_good_errcnt", err_count, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
